// File: rtl/regs_mp.sv
// regs_mp: multi-port integer register file with clear sweep, x0 hardwire, write bypass and collision flag
module regs_mp #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int NUM_READ  = 3,
  parameter int NUM_WRITE = 2,
  parameter bit ZERO_REG  = 1'b1,
  parameter bit BYPASS    = 1'b1,
  localparam int AW = $clog2(REG_COUNT)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_req_i,
  output logic                      ready_o,
  input  logic [NUM_READ*AW-1:0]    rd_addr_i,
  output logic [NUM_READ*XLEN-1:0]  rd_data_o,
  input  logic [NUM_WRITE-1:0]      wr_en_i,
  input  logic [NUM_WRITE*AW-1:0]   wr_addr_i,
  input  logic [NUM_WRITE*XLEN-1:0] wr_data_i,
  output logic                      wr_conflict_o
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic ready_q, conflict_q, conflict_d;
  logic [NUM_WRITE-1:0] we;
  logic [XLEN-1:0] mem_q [REG_COUNT];
  assign ready_o = ready_q;
  assign wr_conflict_o = conflict_q;
  // a write port takes effect only in RUN without clear_req, and never to a hardwired x0
  always_comb begin
    we = '0;
    for (int j = 0; j < NUM_WRITE; j++)
      we[j] = wr_en_i[j] && state_q == RUN && !clear_req_i &&
              !(ZERO_REG && wr_addr_i[j*AW +: AW] == '0);
  end
  // collision: two effective writes to the same address in this cycle
  always_comb begin
    conflict_d = 1'b0;
    for (int j = 0; j < NUM_WRITE; j++)
      for (int k = j + 1; k < NUM_WRITE; k++)
        if (we[j] && we[k] && wr_addr_i[j*AW +: AW] == wr_addr_i[k*AW +: AW])
          conflict_d = 1'b1;
  end
  // sweep index walks every register, then hands over to RUN; clear_req restarts the sweep
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    if (state_q == CLEAR) begin
      idx_d = idx_q + AW'(1);
      if (idx_q == AW'(REG_COUNT - 1)) state_d = RUN;
    end else if (clear_req_i) begin
      state_d = CLEAR;
      idx_d = '0;
    end
  end
  // control state; ready is registered from the next state so it rises with the final sweep edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      idx_q <= '0;
      ready_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      ready_q <= state_d == RUN;
      conflict_q <= conflict_d;
    end
  end
  // storage: sweep zeroes one entry per cycle; in RUN later ports overwrite earlier ones
  always_ff @(posedge clk_i) begin
    if (state_q == CLEAR) mem_q[idx_q] <= '0;
    else
      for (int j = 0; j < NUM_WRITE; j++)
        if (we[j]) mem_q[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
  end
  // combinational reads with optional forwarding from the highest matching write port
  always_comb begin
    logic [AW-1:0] ra;
    logic [XLEN-1:0] rv;
    rd_data_o = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      ra = rd_addr_i[i*AW +: AW];
      rv = mem_q[ra];
      if (BYPASS)
        for (int j = 0; j < NUM_WRITE; j++)
          if (we[j] && wr_addr_i[j*AW +: AW] == ra) rv = wr_data_i[j*XLEN +: XLEN];
      if ((ZERO_REG && ra == '0) || state_q != RUN) rv = '0;
      rd_data_o[i*XLEN +: XLEN] = rv;
    end
  end
endmodule

// File: tb/tb_regs_mp.sv
// tb_regs_mp: directed scoreboard bench for regs_mp (default build and a no-bypass, ordinary-x0 build)
module tb_regs_mp;
  logic clk = 1'b0, rst_n = 1'b1, clear_req = 1'b0;
  logic [14:0] rd_addr = '0;
  logic [1:0] wr_en = '0;
  logic [9:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [95:0] rd_data0, rd_data1;
  logic ready0, ready1, conf0, conf1;
  int tests = 0, fails = 0, n;
  typedef struct {string tag; logic [31:0] exp;} sb_t;
  sb_t sb[$];

  regs_mp d0 (.clk_i(clk), .rst_ni(rst_n), .clear_req_i(clear_req), .ready_o(ready0),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data0), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_conflict_o(conf0));
  regs_mp #(.BYPASS(1'b0), .ZERO_REG(1'b0)) d1 (.clk_i(clk), .rst_ni(rst_n),
    .clear_req_i(clear_req), .ready_o(ready1), .rd_addr_i(rd_addr), .rd_data_o(rd_data1),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_conflict_o(conf1));

  always #5 clk = ~clk;

  function automatic logic [31:0] r0(input int i); return rd_data0[i*32 +: 32]; endfunction
  function automatic logic [31:0] r1(input int i); return rd_data1[i*32 +: 32]; endfunction

  task automatic expect_v(input string tag, input logic [31:0] exp);
    sb.push_back('{tag, exp});
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %h expected none", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic setw(input int j, input logic [4:0] a, input logic [31:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*5 +: 5] = a;
    wr_data[j*32 +: 32] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready0 && cnt < 40) begin
      expect_v("sweep_rd_zero", 32'h0); check(r0(0));
      step();
      cnt++;
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      rd_addr[4:0] = 5'(a);
      #1;
      expect_v({tag, "_d0"}, 32'h0); check(r0(0));
      expect_v({tag, "_d1"}, 32'h0); check(r1(0));
    end
  endtask

  initial begin
    wr_en = 2'b11;
    wr_addr = {5'd9, 5'd4};
    wr_data = {2{32'hDEADBEEF}};
    rd_addr = {3{5'd4}};
    #2 rst_n = 1'b0;
    step(); step();
    expect_v("rst_ready", 32'h0); check(32'(ready0));
    expect_v("rst_conflict", 32'h0); check(32'(conf0));
    expect_v("rst_rd", 32'h0); check(r0(0));
    rst_n = 1'b1;
    wait_ready(n);
    expect_v("sweep_len", 32'd32); check(32'(n));
    expect_v("sweep_ready_d1", 32'h1); check(32'(ready1));
    wr_en = '0;
    read_all_zero("sweep_data");
    step();
    setw(0, 5'd5, 32'h12345678);
    rd_addr[4:0] = 5'd5;
    #1;
    expect_v("bypass_same", 32'h12345678); check(r0(0));
    expect_v("nobypass_same", 32'h0); check(r1(0));
    step();
    wr_en = '0;
    #1;
    expect_v("bypass_after", 32'h12345678); check(r0(0));
    expect_v("nobypass_after", 32'h12345678); check(r1(0));
    step();
    setw(0, 5'd7, 32'h1111);
    setw(1, 5'd7, 32'h2222);
    rd_addr[9:5] = 5'd7;
    #1;
    expect_v("prio_bypass", 32'h2222); check(r0(1));
    expect_v("prio_nobypass_old", 32'h0); check(r1(1));
    expect_v("conf_not_yet", 32'h0); check(32'(conf0));
    step();
    wr_en = '0;
    #1;
    expect_v("conf_pulse_d0", 32'h1); check(32'(conf0));
    expect_v("conf_pulse_d1", 32'h1); check(32'(conf1));
    expect_v("prio_stored_d0", 32'h2222); check(r0(1));
    expect_v("prio_stored_d1", 32'h2222); check(r1(1));
    step();
    expect_v("conf_one_cycle", 32'h0); check(32'(conf0));
    setw(0, 5'd0, 32'h1111);
    setw(1, 5'd0, 32'h2222);
    rd_addr[14:10] = 5'd0;
    #1;
    expect_v("x0_prio_same_d0", 32'h0); check(r0(2));
    expect_v("x0_prio_same_d1", 32'h0); check(r1(2));
    step();
    wr_en = '0;
    #1;
    expect_v("x0_no_conf_d0", 32'h0); check(32'(conf0));
    expect_v("r0_conf_d1", 32'h1); check(32'(conf1));
    expect_v("x0_after_d0", 32'h0); check(r0(2));
    expect_v("r0_after_d1", 32'h2222); check(r1(2));
    step();
    setw(0, 5'd0, 32'hFFFFFFFF);
    setw(1, 5'd0, 32'hFFFFFFFF);
    rd_addr = '0;
    #1;
    for (int i = 0; i < 3; i++) begin expect_v("x0_hw_same", 32'h0); check(r0(i)); end
    step();
    wr_en = '0;
    #1;
    for (int i = 0; i < 3; i++) begin expect_v("x0_hw_after", 32'h0); check(r0(i)); end
    expect_v("r0_ordinary_d1", 32'hFFFFFFFF); check(r1(0));
    expect_v("x0_hw_conf", 32'h0); check(32'(conf0));
    for (int a = 1; a < 32; a++) begin
      setw(0, 5'(a), 32'(a));
      step();
    end
    wr_en = '0;
    rd_addr[4:0] = 5'd3;
    rd_addr[9:5] = 5'd31;
    #1;
    expect_v("fill_r3", 32'd3); check(r0(0));
    expect_v("fill_r31", 32'd31); check(r0(1));
    expect_v("fill_r3_d1", 32'd3); check(r1(0));
    clear_req = 1'b1;
    setw(0, 5'd3, 32'hAA);
    #1;
    expect_v("clr_no_bypass", 32'd3); check(r0(0));
    step();
    clear_req = 1'b0;
    wr_en = '0;
    #1;
    expect_v("clr_ready_low", 32'h0); check(32'(ready0));
    wait_ready(n);
    expect_v("clr_sweep_len", 32'd32); check(32'(n));
    read_all_zero("clr_data");
    step();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    expect_v("mid_rst_ready", 32'h0); check(32'(ready0));
    #3 rst_n = 1'b1;
    #1;
    wait_ready(n);
    expect_v("mid_rst_sweep_len", 32'd32); check(32'(n));
    expect_v("mid_rst_ready_d1", 32'h1); check(32'(ready1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regs_mp.md
Name: regs_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write-port register file in the core datapath.
- Configurable read-port count, write-port count, register count, width, x0-hardwire and write-to-read bypass.
- Sequential clear sweep after reset or on request. A ready flag tells the pipeline when the file is usable.
- Write-port collision detection. Sits between decode (reads) and writeback/mem stages (writes).

Parameters:
- XLEN, 32, data width in bits.
- REG_COUNT, 32, number of registers (power of two, >=2); AW = $clog2(REG_COUNT) is a localparam.
- NUM_READ, 3, number of combinational read ports (>=1).
- NUM_WRITE, 2, number of write ports (>=1); higher index has higher priority.
- ZERO_REG, 1, 1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary.
- BYPASS, 1, 1: same-cycle write data forwarded to matching read ports; 0: reads see stored data only.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- clear_req  input  1  request a full clear sweep; sampled in RUN only.
- ready  output  1  1 = file in RUN, reads/writes valid.
- rd_addr  input  NUM_READ*AW  read addresses; port i at bits [i*AW +: AW].
- rd_data  output  NUM_READ*XLEN  read data; port i at bits [i*XLEN +: XLEN].
- wr_en  input  NUM_WRITE  per-port write enable.
- wr_addr  input  NUM_WRITE*AW  write addresses, packed as rd_addr.
- wr_data  input  NUM_WRITE*XLEN  write data, packed as rd_data.
- wr_conflict  output  1  registered one-cycle pulse: a collision (defined under Behaviour) occurred in the previous cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=CLEAR, idx=0, ready=0, wr_conflict=0.
  - Array contents are not reset directly; they are cleared by the sweep.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle writes data[idx]<=0 and increments idx.
  - On the cycle idx==REG_COUNT-1 is written, next state is RUN and ready<=1 (registered).
  - Sweep takes exactly REG_COUNT cycles after rst deasserts; ready rises on the edge ending the sweep.
  - wr_en ignored; clear_req ignored (the sweep is not restarted); all rd_data forced to 0.
- RUN:
  - clear_req=1: next state is CLEAR, idx<=0, ready<=0 at the same edge.
  - Writes presented in the clear_req cycle are dropped.
  - Otherwise, each enabled write port j writes data[wr_addr_j]<=wr_data_j.
  - If ZERO_REG=1 and wr_addr_j==0, the write is discarded.
- Write priority:
  - Several enabled ports targeting the same address: the highest-index port wins; lower ports to that address are dropped.
- wr_conflict:
  - Set at the next edge when, in a RUN cycle without clear_req, at least two enabled ports target the same address that is actually written (non-zero when ZERO_REG=1).
  - Held 1 for exactly one cycle, else 0.
- Reads (combinational, zero latency):
  - rd_data_i = data[rd_addr_i].
  - If ZERO_REG=1 and rd_addr_i==0, the result is 0 regardless of the bypass.
  - If BYPASS=1, state is RUN, no clear_req, and any port j has wr_en_j with wr_addr_j==rd_addr_i (and writable): rd_data_i = wr_data of the highest such j.
  - BYPASS=0: the written value is visible from the cycle after the write edge.
- Reset mid-sweep or mid-RUN: immediately returns to CLEAR with idx=0. Data written before reset is not guaranteed and is overwritten by the sweep.
- No X may propagate on rd_data after ready=1. Every register has been written at least once by then.

Test Plan:
- Sweep: release rst, hold wr_en=all 1 with data 0xDEADBEEF -> ready=0 for exactly 32 cycles, then 1. All 32 registers read 0; no write took effect.
- Basic write/bypass (BYPASS=1): write port0 addr 5 = 0x12345678 while rd_addr0=5 -> rd_data0=0x12345678 in the same cycle and still after the edge. Repeat with BYPASS=0 -> old value 0 the same cycle, new value the next cycle.
- Priority/conflict: port0 and port1 both write addr 7 (0x1111 and 0x2222) -> data[7]=0x2222, bypass shows 0x2222, wr_conflict=1 for one cycle. Same stimulus to addr 0 -> wr_conflict=0, read of x0=0.
- x0 hardwire: write 0xFFFFFFFF to addr 0 on all ports -> all read ports addressing 0 return 0, before and after the edge. With ZERO_REG=0 the next-cycle read returns 0xFFFFFFFF.
- clear_req: fill regs 1..31 with index values, assert clear_req for one cycle together with a write to addr 3 = 0xAA -> ready low for 32 cycles, reads 0 during the sweep. All registers read 0 after ready=1, including reg 3.
- Async reset mid-sweep: drop rst at sweep cycle 10 for a half cycle -> ready stays 0, the sweep restarts at idx 0, and ready rises 32 cycles after rst release.
